// File: rtl/ring_pkg.sv
// Shared ring types: FSM state encoding plus rotate/onehot helpers.
// Used by the decoder top, its encoder and the ring counter.
package ring_pkg;

  localparam int MAXW = 64;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2
  } ring_state_t;

  function automatic logic onehot(
    input logic [MAXW-1:0] v
  );
    return $countones(v) == 1;
  endfunction

  // rotate left by one within the low w bits
  function automatic logic [MAXW-1:0] rotl(
    input logic [MAXW-1:0] v,
    input int              w
  );
    logic [MAXW-1:0] r;
    r = '0;
    for (int i = 0; i < MAXW; i++) begin
      if (i < w) r[(i + 1) % w] = v[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/ring_decoder_if.sv
// Ring decoder bus: sample input (en, count) and decoded status.
// master drives samples, slave is the decoder.
interface ring_decoder_if #(
  parameter int WIDTH = 8
);
  localparam int IW = $clog2(WIDTH);

  logic             en;
  logic [WIDTH-1:0] count;
  logic [IW-1:0]    index;
  logic             index_valid;
  logic             locked;
  logic             err;
  logic [7:0]       rev_count;
  logic [7:0]       err_count;

  modport master (
    output en, count,
    input  index, index_valid, locked,
    input  err, rev_count, err_count
  );

  modport slave (
    input  en, count,
    output index, index_valid, locked,
    output err, rev_count, err_count
  );
endinterface

// File: rtl/ring_decoder_onehot_enc.sv
// Combinational one-hot to index encoder with is_onehot flag.
// Ports: vec in, idx out (valid only when is_onehot), is_onehot out.
module onehot_enc
  import ring_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int IW    = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IW-1:0]    idx,
  output logic             is_onehot
);

  always_comb begin
    idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (vec[i]) idx = IW'(i);
    end
  end

  assign is_onehot = onehot(MAXW'(vec));

endmodule

// File: rtl/ring_decoder.sv
// Ring counter decoder: checks one-hot left rotation, locks, counts revs.
// Ports: clk, rst_n, bus (ring_decoder_if.slave: en/count in, status out).
module ring_decoder
  import ring_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int LOCK_CNT = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  ring_decoder_if.slave  bus
);

  localparam int IW = $clog2(WIDTH);

  ring_state_t      state;
  logic [3:0]       good_cnt;
  logic [WIDTH-1:0] prev;
  logic [IW-1:0]    cur_idx;
  logic             cur_oh;
  logic             prev_oh;
  logic             seq_ok;
  logic             wrap;

  onehot_enc #(
    .WIDTH (WIDTH),
    .IW    (IW)
  ) u_enc (
    .vec       (bus.count),
    .idx       (cur_idx),
    .is_onehot (cur_oh)
  );

  assign prev_oh = onehot(MAXW'(prev));
  // a stuck ring never matches its own rotation
  assign seq_ok  = cur_oh && prev_oh &&
                   (MAXW'(bus.count) ==
                    rotl(MAXW'(prev), WIDTH));
  assign wrap    = prev[WIDTH-1] && bus.count[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= UNLOCKED;
      good_cnt        <= '0;
      prev            <= '0;
      bus.index       <= '0;
      bus.index_valid <= 1'b0;
      bus.locked      <= 1'b0;
      bus.err         <= 1'b0;
      bus.rev_count   <= '0;
      bus.err_count   <= '0;
    end else begin
      bus.err <= 1'b0;
      if (bus.en) begin
        prev            <= bus.count;
        bus.index_valid <= cur_oh;
        if (cur_oh) bus.index <= cur_idx;
        unique case (state)
          UNLOCKED: begin
            if (cur_oh) begin
              state    <= ACQUIRE;
              good_cnt <= '0;
            end
          end
          ACQUIRE: begin
            if (seq_ok) begin
              good_cnt <= good_cnt + 4'd1;
              if (good_cnt + 4'd1 == 4'(LOCK_CNT)) begin
                state         <= LOCKED;
                bus.locked    <= 1'b1;
                bus.rev_count <= '0;
              end
            end else if (cur_oh) begin
              good_cnt <= '0;
            end else begin
              state <= UNLOCKED;
            end
          end
          LOCKED: begin
            if (seq_ok) begin
              if (wrap) bus.rev_count <= bus.rev_count + 8'd1;
            end else begin
              state      <= UNLOCKED;
              bus.locked <= 1'b0;
              bus.err    <= 1'b1;
              if (bus.err_count != 8'hff)
                bus.err_count <= bus.err_count + 8'd1;
            end
          end
          default: state <= UNLOCKED;
        endcase
      end
    end
  end

endmodule
